// File: rtl/branch_resolve_pkg.sv
// Shared pipeline definitions: default datapath widths, branch FSM encoding
// and the immediate sign-extend helper that decode also uses.
package branch_resolve_pkg;

    localparam int unsigned BR_ADDR_W = 32;
    localparam int unsigned BR_IMM_W  = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        SHADOW = 1'b1
    } br_state_t;

    function automatic logic [BR_ADDR_W-1:0] sign_extend(input logic [BR_IMM_W-1:0] imm);
        return {{(BR_ADDR_W-BR_IMM_W){imm[BR_IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// EX/MEM branch resolution: registers the fetch redirect, drives the IF/ID and
// ID/EX flushes and squashes branches in the shadow of a taken one. BRANCH_BNE_EN adds BNE.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int unsigned ADDR_W        = BR_ADDR_W,
    parameter int unsigned IMM_W         = BR_IMM_W,
    parameter int unsigned SHADOW_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic              ex_is_beq,
    input  logic              ex_is_bne,
    input  logic              ex_zero,
    input  logic [ADDR_W-1:0] ex_pc_plus1,
    input  logic [IMM_W-1:0]  ex_imm,
    output logic              PCSrc,
    output logic [ADDR_W-1:0] PC_from_ExMrm,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              shadow
);

    br_state_t         state_q, state_d;
    logic [1:0]        shadowCnt_q, shadowCnt_d;
    logic              pcSrc_q, pcSrc_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] immExt;
    logic [ADDR_W-1:0] branchTarget;
    logic              take;

    generate
        if (ADDR_W == BR_ADDR_W && IMM_W == BR_IMM_W) begin : g_pkgExt
            assign immExt = sign_extend(ex_imm);
        end else begin : g_genericExt
            assign immExt = {{(ADDR_W-IMM_W){ex_imm[IMM_W-1]}}, ex_imm};
        end
    endgenerate

    // Word-addressed PC, so the offset is added unshifted and wraps silently.
    assign branchTarget = ex_pc_plus1 + immExt;

`ifdef BRANCH_BNE_EN
    assign take = ex_valid & ((ex_is_beq & ex_zero) | (ex_is_bne & ~ex_zero));
`else
    logic unusedBne;
    assign unusedBne = ex_is_bne;
    assign take = ex_valid & ex_is_beq & ex_zero;
`endif

    always_comb begin
        state_d     = state_q;
        shadowCnt_d = shadowCnt_q;
        pcSrc_d     = pcSrc_q;
        target_d    = target_q;
        if (!stall) begin
            unique case (state_q)
                IDLE: begin
                    pcSrc_d = 1'b0;
                    if (take) begin
                        state_d     = SHADOW;
                        shadowCnt_d = 2'(SHADOW_CYCLES);
                        pcSrc_d     = 1'b1;
                        target_d    = branchTarget;
                    end
                end
                SHADOW: begin
                    // Wrong-path instructions in EX are ignored entirely here.
                    pcSrc_d = 1'b0;
                    if (shadowCnt_q <= 2'd1) begin
                        state_d     = IDLE;
                        shadowCnt_d = 2'd0;
                    end else begin
                        shadowCnt_d = shadowCnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    shadowCnt_d = 2'd0;
                    pcSrc_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shadowCnt_q <= 2'd0;
            pcSrc_q     <= 1'b0;
            target_q    <= '0;
        end else begin
            state_q     <= state_d;
            shadowCnt_q <= shadowCnt_d;
            pcSrc_q     <= pcSrc_d;
            target_q    <= target_d;
        end
    end

    assign PCSrc         = pcSrc_q;
    assign PC_from_ExMrm = target_q;
    assign flush_ifid    = pcSrc_q;
    assign flush_idex    = pcSrc_q;
    assign shadow        = (state_q == SHADOW);

endmodule
